// File: rtl/id_alu_issue_pkg.sv
// Shared ALU operation encoding and LA32 opcode field constants for the decode/issue stage.
package id_alu_issue_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 12;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_SLT  = 2;
  localparam int ALU_OP_SLTU = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_NOR  = 5;
  localparam int ALU_OP_OR   = 6;
  localparam int ALU_OP_XOR  = 7;
  localparam int ALU_OP_SLL  = 8;
  localparam int ALU_OP_SRL  = 9;
  localparam int ALU_OP_SRA  = 10;
  localparam int ALU_OP_LUI  = 11;

  localparam alu_op_t ALU_ADD  = alu_op_t'(1) << ALU_OP_ADD;
  localparam alu_op_t ALU_SUB  = alu_op_t'(1) << ALU_OP_SUB;
  localparam alu_op_t ALU_SLT  = alu_op_t'(1) << ALU_OP_SLT;
  localparam alu_op_t ALU_SLTU = alu_op_t'(1) << ALU_OP_SLTU;
  localparam alu_op_t ALU_AND  = alu_op_t'(1) << ALU_OP_AND;
  localparam alu_op_t ALU_NOR  = alu_op_t'(1) << ALU_OP_NOR;
  localparam alu_op_t ALU_OR   = alu_op_t'(1) << ALU_OP_OR;
  localparam alu_op_t ALU_XOR  = alu_op_t'(1) << ALU_OP_XOR;
  localparam alu_op_t ALU_SLL  = alu_op_t'(1) << ALU_OP_SLL;
  localparam alu_op_t ALU_SRL  = alu_op_t'(1) << ALU_OP_SRL;
  localparam alu_op_t ALU_SRA  = alu_op_t'(1) << ALU_OP_SRA;
  localparam alu_op_t ALU_LUI  = alu_op_t'(1) << ALU_OP_LUI;

  // op_31_22 major opcodes
  localparam logic [9:0] OP_3R    = 10'h000;
  localparam logic [9:0] OP_SHIFT = 10'h001;
  localparam logic [9:0] OP_SLTI  = 10'h008;
  localparam logic [9:0] OP_SLTUI = 10'h009;
  localparam logic [9:0] OP_ADDI  = 10'h00A;
  localparam logic [9:0] OP_ANDI  = 10'h00D;
  localparam logic [9:0] OP_ORI   = 10'h00E;
  localparam logic [9:0] OP_XORI  = 10'h00F;
  localparam logic [6:0] OP_LU12I = 7'b0001010;

  // op_19_15 minor opcodes
  localparam logic [4:0] F_ADD  = 5'h00;
  localparam logic [4:0] F_SUB  = 5'h02;
  localparam logic [4:0] F_SLT  = 5'h04;
  localparam logic [4:0] F_SLTU = 5'h05;
  localparam logic [4:0] F_NOR  = 5'h08;
  localparam logic [4:0] F_AND  = 5'h09;
  localparam logic [4:0] F_OR   = 5'h0A;
  localparam logic [4:0] F_XOR  = 5'h0B;
  localparam logic [4:0] F_SLL  = 5'h0E;
  localparam logic [4:0] F_SRL  = 5'h0F;
  localparam logic [4:0] F_SRA  = 5'h10;
  localparam logic [4:0] F_SLLI = 5'h01;
  localparam logic [4:0] F_SRLI = 5'h09;
  localparam logic [4:0] F_SRAI = 5'h11;

  typedef enum logic {DS_EMPTY = 1'b0, DS_FULL = 1'b1} ds_state_e;

endpackage

// File: rtl/id_alu_issue_decode.sv
// Pure combinational LA32 integer-ALU decoder: instruction word to one-hot op, immediate and
// operand-select flags. alu_op is all-zero whenever legal_o is low.
module id_alu_issue_decode
  import id_alu_issue_pkg::*;
(
  input  logic [XLEN-1:0] inst_i,
  output alu_op_t         alu_op_o,
  output logic [XLEN-1:0] imm_o,
  output logic            src2_is_imm_o,
  output logic            src1_is_zero_o,
  output logic            legal_o
);

  logic [9:0] op_31_22;
  logic [1:0] op_21_20;
  logic [4:0] op_19_15;

  assign op_31_22 = inst_i[31:22];
  assign op_21_20 = inst_i[21:20];
  assign op_19_15 = inst_i[19:15];

  always_comb begin
    alu_op_o       = '0;
    imm_o          = '0;
    src2_is_imm_o  = 1'b0;
    src1_is_zero_o = 1'b0;
    legal_o        = 1'b1;
    if (op_31_22 == OP_3R && op_21_20 == 2'b01) begin
      case (op_19_15)
        F_ADD:   alu_op_o = ALU_ADD;
        F_SUB:   alu_op_o = ALU_SUB;
        F_SLT:   alu_op_o = ALU_SLT;
        F_SLTU:  alu_op_o = ALU_SLTU;
        F_NOR:   alu_op_o = ALU_NOR;
        F_AND:   alu_op_o = ALU_AND;
        F_OR:    alu_op_o = ALU_OR;
        F_XOR:   alu_op_o = ALU_XOR;
        F_SLL:   alu_op_o = ALU_SLL;
        F_SRL:   alu_op_o = ALU_SRL;
        F_SRA:   alu_op_o = ALU_SRA;
        default: legal_o  = 1'b0;
      endcase
    end else if (op_31_22 == OP_SHIFT && op_21_20 == 2'b00) begin
      src2_is_imm_o = 1'b1;
      imm_o         = {27'b0, inst_i[14:10]};
      case (op_19_15)
        F_SLLI:  alu_op_o = ALU_SLL;
        F_SRLI:  alu_op_o = ALU_SRL;
        F_SRAI:  alu_op_o = ALU_SRA;
        default: legal_o  = 1'b0;
      endcase
    end else if (inst_i[31:25] == OP_LU12I) begin
      alu_op_o       = ALU_LUI;
      src2_is_imm_o  = 1'b1;
      src1_is_zero_o = 1'b1;
      imm_o          = {inst_i[24:5], 12'b0};
    end else begin
      // 2RI12 group: arithmetic forms sign-extend, logical forms zero-extend
      src2_is_imm_o = 1'b1;
      case (op_31_22)
        OP_SLTI:  begin alu_op_o = ALU_SLT;  imm_o = {{20{inst_i[21]}}, inst_i[21:10]}; end
        OP_SLTUI: begin alu_op_o = ALU_SLTU; imm_o = {{20{inst_i[21]}}, inst_i[21:10]}; end
        OP_ADDI:  begin alu_op_o = ALU_ADD;  imm_o = {{20{inst_i[21]}}, inst_i[21:10]}; end
        OP_ANDI:  begin alu_op_o = ALU_AND;  imm_o = {20'b0, inst_i[21:10]}; end
        OP_ORI:   begin alu_op_o = ALU_OR;   imm_o = {20'b0, inst_i[21:10]}; end
        OP_XORI:  begin alu_op_o = ALU_XOR;  imm_o = {20'b0, inst_i[21:10]}; end
        default:  legal_o = 1'b0;
      endcase
    end
    if (!legal_o) begin
      alu_op_o       = '0;
      imm_o          = '0;
      src2_is_imm_o  = 1'b0;
      src1_is_zero_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_alu_issue.sv
// Decode-stage issue register: one-entry valid/ready slot, result visible the cycle after accept,
// 1/cycle throughput; in_ready drops only when full and EX stalls, outputs hold while stalled.
module id_alu_issue
  import id_alu_issue_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_inst,
  input  logic                flush,
  output logic [4:0]          rf_raddr1,
  output logic [4:0]          rf_raddr2,
  input  logic [XLEN-1:0]     rf_rdata1,
  input  logic [XLEN-1:0]     rf_rdata2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [XLEN-1:0]     out_alu_src1,
  output logic [XLEN-1:0]     out_alu_src2,
  output logic [4:0]          out_dest,
  output logic                out_gr_we,
  output logic                out_dec_err
);

  ds_state_e       state_q, state_d;
  logic [XLEN-1:0] ds_pc_q, ds_pc_d;
  logic [XLEN-1:0] ds_inst_q, ds_inst_d;
  logic            load;

  assign in_ready = (state_q == DS_EMPTY) | out_ready;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DS_EMPTY;
      ds_pc_q   <= '0;
      ds_inst_q <= '0;
    end else begin
      state_q   <= state_d;
      ds_pc_q   <= ds_pc_d;
      ds_inst_q <= ds_inst_d;
    end
  end

  // flush wins over both a new load and a hold; the offered instruction is simply not captured
  always_comb begin
    state_d   = state_q;
    ds_pc_d   = ds_pc_q;
    ds_inst_d = ds_inst_q;
    if (flush) begin
      state_d = DS_EMPTY;
    end else if (load) begin
      state_d   = DS_FULL;
      ds_pc_d   = in_pc;
      ds_inst_d = in_inst;
    end else if (state_q == DS_FULL && out_ready) begin
      state_d = DS_EMPTY;
    end
  end

  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_src2_imm;
  logic            dec_src1_zero;
  logic            dec_legal;

  id_alu_issue_decode u_decode (
    .inst_i         (ds_inst_q),
    .alu_op_o       (dec_op),
    .imm_o          (dec_imm),
    .src2_is_imm_o  (dec_src2_imm),
    .src1_is_zero_o (dec_src1_zero),
    .legal_o        (dec_legal)
  );

  assign rf_raddr1    = ds_inst_q[9:5];
  assign rf_raddr2    = ds_inst_q[14:10];
  assign out_valid    = (state_q == DS_FULL);
  assign out_pc       = ds_pc_q;
  assign out_alu_op   = dec_op;
  assign out_dest     = ds_inst_q[4:0];
  assign out_alu_src1 = (!dec_legal || dec_src1_zero) ? '0 : rf_rdata1;
  assign out_alu_src2 = !dec_legal ? '0 : (dec_src2_imm ? dec_imm : rf_rdata2);
  assign out_gr_we    = dec_legal & (ds_inst_q[4:0] != 5'd0);
  assign out_dec_err  = ~dec_legal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Bench for id_alu_issue: directed scenarios plus a randomized stream against a table-driven model.
module tb_id_alu_issue;

  logic        clk = 1'b0;
  logic        resetn, in_valid, in_ready, flush, out_valid, out_ready, out_gr_we, out_dec_err;
  logic [31:0] in_pc, in_inst, rf_rdata1, rf_rdata2, out_pc, out_alu_src1, out_alu_src2;
  logic [4:0]  rf_raddr1, rf_raddr2, out_dest;
  logic [11:0] out_alu_op;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];

  id_alu_issue dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_op(out_alu_op), .out_alu_src1(out_alu_src1),
    .out_alu_src2(out_alu_src2), .out_dest(out_dest), .out_gr_we(out_gr_we),
    .out_dec_err(out_dec_err)
  );

  typedef struct packed {
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        we;
    logic        err;
  } pkt_t;

  // Instruction table: (inst & mask) == match selects ALU op index and operand kind
  // kind 0: rj,rk  1: rj,ui5  2: rj,si12  3: rj,ui12  4: 0,ui20<<12
  logic [31:0] pat_mask [21] = '{
    32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000,
    32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000,
    32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000,
    32'hFFC00000, 32'hFFC00000, 32'hFFC00000, 32'hFFC00000, 32'hFFC00000, 32'hFFC00000,
    32'hFE000000};
  logic [31:0] pat_match [21] = '{
    32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000, 32'h00140000, 32'h00148000,
    32'h00150000, 32'h00158000, 32'h00170000, 32'h00178000, 32'h00180000,
    32'h00408000, 32'h00448000, 32'h00488000,
    32'h02000000, 32'h02400000, 32'h02800000, 32'h03400000, 32'h03800000, 32'h03C00000,
    32'h14000000};
  int pat_op [21]   = '{0, 1, 2, 3, 5, 4, 6, 7, 8, 9, 10, 8, 9, 10, 2, 3, 0, 4, 6, 7, 11};
  int pat_kind [21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4};

  // Architectural view of the stage: what instruction (if any) is being presented to EX
  logic        m_valid;
  logic [31:0] m_pc, m_inst;

  function automatic logic [31:0] rd_rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  function automatic pkt_t ref_pkt(input logic [31:0] inst);
    pkt_t e;
    e = '0;
    e.err  = 1'b1;
    e.dest = inst[4:0];
    for (int i = 0; i < 21; i++) begin
      if ((inst & pat_mask[i]) == pat_match[i]) begin
        e.err = 1'b0;
        e.we  = (inst[4:0] != 5'd0);
        e.op  = 12'd1 << pat_op[i];
        e.s1  = rd_rf(inst[9:5]);
        case (pat_kind[i])
          0:       e.s2 = rd_rf(inst[14:10]);
          1:       e.s2 = {27'd0, inst[14:10]};
          2:       e.s2 = {{20{inst[21]}}, inst[21:10]};
          3:       e.s2 = {20'd0, inst[21:10]};
          default: begin e.s1 = 32'd0; e.s2 = {inst[24:5], 12'd0}; end
        endcase
      end
    end
    return e;
  endfunction

  function automatic pkt_t mk(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [4:0] dest, input logic we, input logic err);
    pkt_t e;
    e.op = op; e.s1 = s1; e.s2 = s2; e.dest = dest; e.we = we; e.err = err;
    return e;
  endfunction

  function automatic pkt_t dut_pkt();
    return {out_alu_op, out_alu_src1, out_alu_src2, out_dest, out_gr_we, out_dec_err};
  endfunction

  function automatic logic [31:0] gen_inst();
    int k;
    k = $urandom_range(0, 25);
    if (k >= 21) return $urandom;
    return pat_match[k] | ($urandom & ~pat_mask[k]);
  endfunction

  // Advance one clock, updating the architectural view from the inputs offered this cycle
  task automatic tick();
    logic        nv;
    logic [31:0] npc, ninst;
    nv = m_valid; npc = m_pc; ninst = m_inst;
    if (flush) nv = 1'b0;
    else if (in_valid && (!m_valid || out_ready)) begin nv = 1'b1; npc = in_pc; ninst = in_inst; end
    else if (out_ready) nv = 1'b0;
    @(posedge clk);
    #1;
    m_valid = nv; m_pc = npc; m_inst = ninst;
  endtask

  task automatic issue_one(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst; out_ready = 1'b1; flush = 1'b0;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_pc = '0; in_inst = '0;
    m_valid = 1'b0; m_pc = '0; m_inst = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (dut_pkt() !== mk(12'h000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL reset_decode got %h exp %h", dut_pkt(), mk(12'h000, 0, 0, 0, 0, 1)); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    resetn = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_add();
    rf[1] = 32'd5; rf[2] = 32'd7;
    issue_one(32'h0000_0100, 32'h0010_0823);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL add_pc got %h exp 100", out_pc); end
    checks++; if (dut_pkt() !== mk(12'h001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0)) begin
      errors++; $display("FAIL add_pkt got %h exp %h", dut_pkt(), mk(12'h001, 5, 7, 3, 1, 0)); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_imm();
    rf[1] = 32'h1234_5678;
    issue_one(32'h110, 32'h02BF_FC24);
    checks++; if (dut_pkt() !== mk(12'h001, 32'h12345678, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0)) begin
      errors++; $display("FAIL addi_pkt got %h exp %h", dut_pkt(), mk(12'h001, 32'h12345678, 32'hFFFFFFFF, 4, 1, 0)); end
    drain();
    issue_one(32'h114, 32'h03FF_FC24);
    checks++; if (dut_pkt() !== mk(12'h080, 32'h12345678, 32'h00000FFF, 5'd4, 1'b1, 1'b0)) begin
      errors++; $display("FAIL xori_pkt got %h exp %h", dut_pkt(), mk(12'h080, 32'h12345678, 32'hFFF, 4, 1, 0)); end
    drain();
    issue_one(32'h118, 32'h037F_FC24);
    checks++; if (dut_pkt() !== mk(12'h010, 32'h12345678, 32'h00000FFF, 5'd4, 1'b1, 1'b0)) begin
      errors++; $display("FAIL andi_pkt got %h exp %h", dut_pkt(), mk(12'h010, 32'h12345678, 32'hFFF, 4, 1, 0)); end
    drain();
  endtask

  task automatic test_lui();
    rf[5] = 32'hCAFE_F00D;
    issue_one(32'h120, 32'h1424_68A5);
    checks++; if (dut_pkt() !== mk(12'h800, 32'd0, 32'h12345000, 5'd5, 1'b1, 1'b0)) begin
      errors++; $display("FAIL lui_pkt got %h exp %h", dut_pkt(), mk(12'h800, 0, 32'h12345000, 5, 1, 0)); end
    drain();
  endtask

  task automatic test_backpressure();
    rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'd3; rf[4] = 32'd9;
    issue_one(32'h200, 32'h0011_0826);
    in_valid = 1'b1; in_pc = 32'h204; in_inst = 32'h0015_1067;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b exp 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 ||
                    dut_pkt() !== mk(12'h002, 32'd5, 32'd7, 5'd6, 1'b1, 1'b0)) begin
        errors++; $display("FAIL bp_hold c%0d got v=%b pc=%h pkt=%h", c, out_valid, out_pc, dut_pkt()); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
      errors++; $display("FAIL bp_reload got v=%b pc=%h exp v=1 pc=204", out_valid, out_pc); end
    checks++; if (dut_pkt() !== mk(12'h040, 32'd3, 32'd9, 5'd7, 1'b1, 1'b0)) begin
      errors++; $display("FAIL bp_reload_pkt got %h exp %h", dut_pkt(), mk(12'h040, 3, 9, 7, 1, 0)); end
    drain();
  endtask

  task automatic test_illegal_flush();
    issue_one(32'h300, 32'hFFFF_FFFF);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_valid got %b exp 1", out_valid); end
    checks++; if (dut_pkt() !== mk(12'h000, 32'd0, 32'd0, 5'd31, 1'b0, 1'b1)) begin
      errors++; $display("FAIL ill_pkt got %h exp %h", dut_pkt(), mk(12'h000, 0, 0, 31, 0, 1)); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h304; in_inst = 32'h0010_0823; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped c%0d got %b exp 0", c, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    issue_one(32'h400, 32'h0010_0823);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_loaded got %b exp 1", out_valid); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ar_immediate got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    m_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    pkt_t exp_p;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 31)] = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_inst   = gen_inst();
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL rnd_in_ready c%0d got %b exp %b", c, in_ready, (!m_valid || out_ready)); end
      checks++; if (out_valid !== m_valid) begin
        errors++; $display("FAIL rnd_out_valid c%0d got %b exp %b", c, out_valid, m_valid); end
      if (m_valid) begin
        exp_p = ref_pkt(m_inst);
        checks++; if (dut_pkt() !== exp_p || out_pc !== m_pc) begin
          errors++; $display("FAIL rnd_pkt c%0d inst %h got %h/%h exp %h/%h", c, m_inst, dut_pkt(), out_pc, exp_p, m_pc); end
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    test_reset();
    test_add();
    test_imm();
    test_lui();
    test_backpressure();
    test_illegal_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
